keypad_scanner: RTL and testbench



---
 rtl/keypad_scanner.sv | 204 ++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one column driven low at a time, debounced press/release, one-cycle key event.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
   parameter int unsigned SCAN_CYCLES     = 48_000,
   parameter int unsigned DEBOUNCE_CYCLES = 960_000,
   parameter int unsigned REPEAT_CYCLES   = 24_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] cols,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   localparam int unsigned BASE_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
`ifdef KEYPAD_REPEAT_EN
   localparam int unsigned MAX_CYCLES = (REPEAT_CYCLES > BASE_MAX) ? REPEAT_CYCLES : BASE_MAX;
`else
   localparam int unsigned MAX_CYCLES = BASE_MAX;
`endif
   localparam int unsigned CNT_W = $clog2(MAX_CYCLES) + 1;

   if (SCAN_CYCLES < 4 || DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("keypad_scanner: cycle parameters out of range");
   end

   typedef enum logic [2:0] {
      SCAN,
      DEBOUNCE,
      PRESSED,
      HOLD,
      RELEASE
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [1:0]       col_idx, col_idx_n;
   logic [1:0]       row_idx, row_idx_n;
   logic [3:0]       cols_n;
   logic [3:0]       key_code_n;
   logic             key_valid_n;
   logic             key_held_n;
   logic [3:0]       rows_m, rows_s;
   logic [1:0]       low_row;
   logic             any_low;
   logic             key_low;
`ifdef KEYPAD_REPEAT_EN
   logic [CNT_W-1:0] rep_cnt, rep_cnt_n;
`endif

   // Row-major hex legend of the keypad.
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      case ({r, c})
         4'h0: key_map = 4'h1;
         4'h1: key_map = 4'h2;
         4'h2: key_map = 4'h3;
         4'h3: key_map = 4'hA;
         4'h4: key_map = 4'h4;
         4'h5: key_map = 4'h5;
         4'h6: key_map = 4'h6;
         4'h7: key_map = 4'hB;
         4'h8: key_map = 4'h7;
         4'h9: key_map = 4'h8;
         4'hA: key_map = 4'h9;
         4'hB: key_map = 4'hC;
         4'hC: key_map = 4'hE;
         4'hD: key_map = 4'h0;
         4'hE: key_map = 4'hF;
         default: key_map = 4'hD;
      endcase
   endfunction

   // Two-flop synchronizer for the asynchronous row pins.
   always_ff @(posedge clk) begin
      if (reset) begin
         rows_m <= 4'hF;
         rows_s <= 4'hF;
      end else begin
         rows_m <= rows;
         rows_s <= rows_m;
      end
   end

   // Lowest-index low row wins when several keys share the driven column.
   always_comb begin
      low_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (!rows_s[i]) low_row = 2'(i);
      end
      any_low = (rows_s != 4'hF);
      key_low = ~rows_s[row_idx];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= SCAN;
         cnt       <= '0;
         col_idx   <= 2'd0;
         row_idx   <= 2'd0;
         cols      <= 4'b1110;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= '0;
`endif
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         col_idx   <= col_idx_n;
         row_idx   <= row_idx_n;
         cols      <= cols_n;
         key_code  <= key_code_n;
         key_valid <= key_valid_n;
         key_held  <= key_held_n;
`ifdef KEYPAD_REPEAT_EN
         rep_cnt   <= rep_cnt_n;
`endif
      end
   end

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      col_idx_n   = col_idx;
      row_idx_n   = row_idx;
      key_code_n  = key_code;
      key_valid_n = 1'b0;
      key_held_n  = key_held;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_n   = rep_cnt;
`endif
      case (state)
         SCAN: begin
            if (cnt == CNT_W'(SCAN_CYCLES - 1)) begin
               cnt_n = '0;
               if (any_low) begin
                  row_idx_n = low_row;
                  state_n   = DEBOUNCE;
               end else begin
                  col_idx_n = col_idx + 2'd1;
               end
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         DEBOUNCE: begin
            if (!key_low) begin
               state_n = SCAN;
               cnt_n   = '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               state_n = PRESSED;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         PRESSED: begin
            key_code_n  = key_map(row_idx, col_idx);
            key_valid_n = 1'b1;
            key_held_n  = 1'b1;
            state_n     = HOLD;
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_n   = '0;
`endif
         end
         HOLD: begin
            if (!key_low) begin
               state_n = RELEASE;
               cnt_n   = '0;
`ifdef KEYPAD_REPEAT_EN
               rep_cnt_n = '0;
            end else if (rep_cnt == CNT_W'(REPEAT_CYCLES - 1)) begin
               rep_cnt_n   = '0;
               key_valid_n = 1'b1;
            end else begin
               rep_cnt_n = rep_cnt + CNT_W'(1);
`endif
            end
         end
         RELEASE: begin
            if (key_low) begin
               state_n = HOLD;
               cnt_n   = '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               key_held_n = 1'b0;
               col_idx_n  = col_idx + 2'd1;
               state_n    = SCAN;
               cnt_n      = '0;
            end else begin
               cnt_n = cnt + CNT_W'(1);
            end
         end
         default: begin
            state_n = SCAN;
            cnt_n   = '0;
         end
      endcase
      cols_n = ~(4'b0001 << col_idx_n);
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: a keypad model reacts to cols, stimulus queues expected key events,
// a monitor pops and compares on every key_valid. Honours KEYPAD_REPEAT_EN for repeat pulses.
module tb_keypad_scanner;

   localparam int unsigned SCAN = 8;
   localparam int unsigned DEB  = 16;
   localparam int unsigned REP  = 64;

   localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                          4'h4, 4'h5, 4'h6, 4'hB,
                                          4'h7, 4'h8, 4'h9, 4'hC,
                                          4'hE, 4'h0, 4'hF, 4'hD};

   typedef struct packed {
      logic [3:0] code;
      logic [1:0] col;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  rows;
   logic [3:0]  cols;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_held;
   logic [15:0] pressed = '0;

   exp_t        exp_q[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_pulse = 0;
   int          repeats = 0;
   logic [3:0]  last_code = 4'h0;
   logic [1:0]  last_col = 2'd0;
   logic        prev_held = 1'b0;
   logic [3:0]  ec;

   keypad_scanner #(
      .SCAN_CYCLES(SCAN),
      .DEBOUNCE_CYCLES(DEB),
      .REPEAT_CYCLES(REP)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rows(rows),
      .cols(cols),
      .key_code(key_code),
      .key_valid(key_valid),
      .key_held(key_held)
   );

   always #5 clk = ~clk;

   // Passive matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      rows = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: compares every event against the scoreboard and tracks key_code/key_held behaviour.
   always begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         check("reset_cols", 32'(cols), 32'(4'b1110));
         check("reset_valid", 32'(key_valid), 0);
         check("reset_held", 32'(key_held), 0);
         check("reset_code", 32'(key_code), 0);
         last_code = 4'h0;
         prev_held = 1'b0;
      end else begin
         if (key_valid) begin
`ifdef KEYPAD_REPEAT_EN
            if (prev_held) begin
               repeats++;
               check("repeat_code", 32'(key_code), 32'(last_code));
               check("repeat_interval", 32'(cyc - last_pulse), REP);
            end else
`endif
            begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_pulse: key_valid=1 code %0h, expected no pulse", key_code);
               end else begin
                  e = exp_q.pop_front();
                  check("key_code", 32'(key_code), 32'(e.code));
                  last_code = e.code;
                  last_col  = e.col;
               end
            end
            last_pulse = cyc;
            check("held_with_pulse", 32'(key_held), 1);
         end else begin
            check("code_hold", 32'(key_code), 32'(last_code));
         end
         if (prev_held && !key_held) begin
            ec = ~(4'b0001 << (last_col + 2'd1));
            check("cols_after_release", 32'(cols), 32'(ec));
         end
         prev_held = key_held;
      end
   end

   // One press episode: optional press bounce, steady hold, optional extra/ignored keys, release bounce.
   task automatic episode(input int r, input int c, input int extra_r, input int hold, input bit bin,
                          input int bout_n, input int bout_hi, input int bout_lo,
                          input int other_r, input int other_c);
      int   idx;
      int   main_r;
      exp_t x;
      logic [3:0] hc;
      idx    = r * 4 + c;
      main_r = (extra_r >= 0 && extra_r < r) ? extra_r : r;
      if (bin) begin
         repeat ($urandom_range(3, 1)) begin
            pressed[idx] = 1'b1;
            tick(int'($urandom_range(8, 1)));
            pressed[idx] = 1'b0;
            tick(int'($urandom_range(3, 1)));
         end
      end
      pressed[idx] = 1'b1;
      if (extra_r >= 0) pressed[extra_r*4+c] = 1'b1;
      x.code = KEYMAP[main_r*4+c];
      x.col  = 2'(c);
      exp_q.push_back(x);
      tick(hold);
      hc = ~(4'b0001 << c);
      check("held_during_hold", 32'(key_held), 1);
      check("cols_during_hold", 32'(cols), 32'(hc));
      if (other_r >= 0) begin
         pressed[other_r*4+other_c] = 1'b1;
         tick(30);
         check("held_with_other", 32'(key_held), 1);
         pressed[other_r*4+other_c] = 1'b0;
         tick(10);
      end
      pressed[idx] = 1'b0;
      if (extra_r >= 0) pressed[extra_r*4+c] = 1'b0;
      for (int k = 0; k < bout_n; k++) begin
         tick(bout_hi);
         check("held_release_bounce", 32'(key_held), 1);
         pressed[main_r*4+c] = 1'b1;
         tick(bout_lo);
         pressed[main_r*4+c] = 1'b0;
      end
      tick(int'(DEB) + 30);
      check("held_after_release", 32'(key_held), 0);
   endtask

   initial begin
      logic [3:0] xc;
      int r, c, er, orr, oc, rep0;
      reset   = 1'b1;
      pressed = '0;
      tick(3);
      reset = 1'b0;
      // Idle scan walks the columns, SCAN clocks each.
      for (int k = 0; k < 40; k++) begin
         xc = ~(4'b0001 << ((k / int'(SCAN)) % 4));
         check("idle_scan_cols", 32'(cols), 32'(xc));
         tick(1);
      end

      episode(1, 1, -1, 100, 0, 0, 1, 1, -1, 0);          // key 5
      pressed[13] = 1'b1; tick(5); pressed[13] = 1'b0; tick(1);
      episode(3, 1, -1, 100, 0, 0, 1, 1, -1, 0);          // key 0 after bounce
      episode(3, 3, -1, 80, 0, 4, 4, 1, -1, 0);           // key D with release bounce
      episode(0, 0, 1, 80, 0, 0, 1, 1, 1, 3);             // keys 1+4, B ignored

      // Reset while debouncing key 2 drops the event.
      reset = 1'b1;
      tick(2);
      pressed[1] = 1'b1;
      reset = 1'b0;
      tick(24);
      reset = 1'b1;
      tick(1);
      check("mid_reset_cols", 32'(cols), 32'(4'b1110));
      check("mid_reset_valid", 32'(key_valid), 0);
      check("mid_reset_held", 32'(key_held), 0);
      pressed[1] = 1'b0;
      tick(2);
      reset = 1'b0;
      tick(60);

      rep0 = repeats;
      episode(2, 2, -1, 200, 0, 0, 1, 1, -1, 0);          // key 9 long hold
`ifdef KEYPAD_REPEAT_EN
      check("repeat_count_ok", 32'(repeats - rep0 >= 2), 1);
`else
      check("no_repeats", 32'(repeats - rep0), 0);
`endif

      for (int n = 0; n < 20; n++) begin
         r  = int'($urandom_range(3, 0));
         c  = int'($urandom_range(3, 0));
         er = -1;
         if ($urandom_range(2, 0) == 0) er = (r + int'($urandom_range(3, 1))) % 4;
         orr = -1;
         oc  = 0;
         if ($urandom_range(2, 0) == 0) begin
            orr = int'($urandom_range(3, 0));
            oc  = (c + int'($urandom_range(3, 1))) % 4;
         end
         episode(r, c, er, int'($urandom_range(150, 70)), 1'($urandom_range(1, 0)),
                 int'($urandom_range(3, 0)), int'($urandom_range(8, 1)), int'($urandom_range(3, 1)),
                 orr, oc);
      end

      tick(50);
      check("queue_empty", 32'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #800000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
